// File: rtl/munoc_quiesce_controller_pkg.sv
// Shared types, state encodings and parameter defaults for the uNoC quiesce controller.
package munoc_quiesce_controller_pkg;

  localparam int unsigned DEF_MAX_OUTSTANDING = 16;
  localparam int unsigned DEF_TIMEOUT_CYCLES  = 1024;

  // Encodings are fixed so that debug views and the gate-side decode agree.
  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_PEND     = 2'd1,
    ST_DRAIN    = 2'd2,
    ST_QUIESCED = 2'd3
  } qstate_e;

  function automatic int unsigned cnt_width(input int unsigned max_out);
    return $clog2(max_out + 1);
  endfunction

endpackage

// File: rtl/munoc_quiesce_controller_if.sv
// Observed request/response handshake of one gated uNoC link.
interface munoc_quiesce_controller_if;

  logic req_valid_obs;
  logic req_ready_obs;
  logic rsp_valid_obs;
  logic rsp_ready_obs;
  logic rsp_last_obs;

  modport master (
    output req_valid_obs,
    output req_ready_obs,
    output rsp_valid_obs,
    output rsp_ready_obs,
    output rsp_last_obs
  );

  modport slave (
    input req_valid_obs,
    input req_ready_obs,
    input rsp_valid_obs,
    input rsp_ready_obs,
    input rsp_last_obs
  );

endinterface

// File: rtl/munoc_outstanding_counter.sv
// Saturating in-flight transaction counter with sticky overflow/underflow flags.
module munoc_outstanding_counter
  import munoc_quiesce_controller_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = DEF_MAX_OUTSTANDING,
  parameter int unsigned CNT_W           = cnt_width(MAX_OUTSTANDING)
) (
  input  logic             clk,
  input  logic             rstnn,
  input  logic             inc_i,
  input  logic             dec_i,
  input  logic             err_clear_i,
  output logic [CNT_W-1:0] count_o,
  output logic [CNT_W-1:0] count_next_c,
  output logic             overflow_err_o,
  output logic             underflow_err_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             ovf_ev, unf_ev;

  // Simultaneous inc and dec cancel; saturation holds the count and flags the event.
  always_comb begin
    count_d = count_q;
    ovf_ev  = 1'b0;
    unf_ev  = 1'b0;
    if (inc_i && !dec_i) begin
      if (count_q == CNT_MAX) ovf_ev = 1'b1;
      else                    count_d = count_q + CNT_W'(1);
    end else if (dec_i && !inc_i) begin
      if (count_q == '0) unf_ev = 1'b1;
      else               count_d = count_q - CNT_W'(1);
    end
    // A fresh event outranks a clear in the same cycle.
    ovf_d = ovf_ev | (ovf_q & ~err_clear_i);
    unf_d = unf_ev | (unf_q & ~err_clear_i);
  end

  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign count_o         = count_q;
  assign count_next_c    = count_d;
  assign overflow_err_o  = ovf_q;
  assign underflow_err_o = unf_q;

endmodule

// File: rtl/munoc_quiesce_controller.sv
// Blocks a uNoC channel at a handshake boundary and acknowledges once all
// outstanding responses have returned; includes a drain watchdog.
module munoc_quiesce_controller
  import munoc_quiesce_controller_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = DEF_MAX_OUTSTANDING,
  parameter int unsigned TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES,
  localparam int unsigned CNT_W          = cnt_width(MAX_OUTSTANDING)
) (
  input  logic                             clk,
  input  logic                             rstnn,
  input  logic                             quiesce_req,
  output logic                             quiesce_ack,
  output logic                             block,
  munoc_quiesce_controller_if.slave        obs_if,
  input  logic                             err_clear,
  output logic [CNT_W-1:0]                 outstanding,
  output logic                             overflow_err,
  output logic                             underflow_err,
  output logic                             timeout_err
);

  localparam int unsigned   WD_W    = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit            WD_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [WD_W-1:0] WD_MAX  = WD_W'(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES) - WD_W'(1);

  qstate_e          state_q, state_d;
  logic             block_q, block_d;
  logic             ack_q, ack_d;
  logic [WD_W-1:0]  wdog_q, wdog_d;
  logic             timeout_q, timeout_d;
  logic             to_ev;
  logic             wd_active;
  logic             inc, dec;
  logic [CNT_W-1:0] cnt_q, cnt_next;

  assign inc = obs_if.req_valid_obs & obs_if.req_ready_obs;
  assign dec = obs_if.rsp_valid_obs & obs_if.rsp_ready_obs & obs_if.rsp_last_obs;

  munoc_outstanding_counter #(
    .MAX_OUTSTANDING (MAX_OUTSTANDING),
    .CNT_W           (CNT_W)
  ) u_counter (
    .clk             (clk),
    .rstnn           (rstnn),
    .inc_i           (inc),
    .dec_i           (dec),
    .err_clear_i     (err_clear),
    .count_o         (cnt_q),
    .count_next_c    (cnt_next),
    .overflow_err_o  (overflow_err),
    .underflow_err_o (underflow_err)
  );

  // Next-state and registered-output decode; dropping quiesce_req always wins.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RUN: begin
        if (quiesce_req) state_d = ST_PEND;
      end
      ST_PEND: begin
        if (!quiesce_req)                           state_d = ST_RUN;
        else if (!obs_if.req_valid_obs || inc)      state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!quiesce_req)         state_d = ST_RUN;
        else if (cnt_next == '0)  state_d = ST_QUIESCED;
      end
      ST_QUIESCED: begin
        if (!quiesce_req) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
    block_d = (state_d == ST_DRAIN) || (state_d == ST_QUIESCED);
    ack_d   = (state_d == ST_QUIESCED);
  end

  // Watchdog restarts on PEND entry and saturates once it has fired.
  always_comb begin
    wd_active = (state_q == ST_PEND) || (state_q == ST_DRAIN);
    wdog_d    = wdog_q;
    to_ev     = 1'b0;
    if ((state_d == ST_PEND) && (state_q != ST_PEND)) begin
      wdog_d = '0;
    end else if (WD_EN && wd_active && (wdog_q != WD_MAX)) begin
      wdog_d = wdog_q + WD_W'(1);
      to_ev  = (wdog_q == WD_LAST);
    end
    timeout_d = to_ev | (timeout_q & ~err_clear);
  end

  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      state_q   <= ST_RUN;
      block_q   <= 1'b0;
      ack_q     <= 1'b0;
      wdog_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      block_q   <= block_d;
      ack_q     <= ack_d;
      wdog_q    <= wdog_d;
      timeout_q <= timeout_d;
    end
  end

  assign block       = block_q;
  assign quiesce_ack = ack_q;
  assign outstanding = cnt_q;
  assign timeout_err = timeout_q;

endmodule

// File: tb/tb_munoc_quiesce_controller.sv
// Directed plus randomized bench for the quiesce controller against a behavioural model.
module tb_munoc_quiesce_controller;

  localparam int unsigned MAXO = 4;
  localparam int unsigned TMO  = 8;
  localparam int unsigned CW   = $clog2(MAXO + 1);

  // Model phases: idle, waiting for a request boundary, draining, drained.
  localparam int P_IDLE = 0, P_WAIT = 1, P_DRAIN = 2, P_DONE = 3;

  logic          clk = 1'b0;
  logic          rstnn;
  logic          quiesce_req, quiesce_ack, block, err_clear;
  logic [CW-1:0] outstanding;
  logic          overflow_err, underflow_err, timeout_err;

  munoc_quiesce_controller_if obs_if ();

  munoc_quiesce_controller #(
    .MAX_OUTSTANDING (MAXO),
    .TIMEOUT_CYCLES  (TMO)
  ) dut (
    .clk           (clk),
    .rstnn         (rstnn),
    .quiesce_req   (quiesce_req),
    .quiesce_ack   (quiesce_ack),
    .block         (block),
    .obs_if        (obs_if.slave),
    .err_clear     (err_clear),
    .outstanding   (outstanding),
    .overflow_err  (overflow_err),
    .underflow_err (underflow_err),
    .timeout_err   (timeout_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  int m_cnt, m_phase, m_age;
  bit m_ov, m_un, m_to;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int exp_blk;
    exp_blk = (m_phase == P_DRAIN || m_phase == P_DONE) ? 1 : 0;
    check({tag, "/block"},     int'(block),         exp_blk);
    check({tag, "/ack"},       int'(quiesce_ack),   (m_phase == P_DONE) ? 1 : 0);
    check({tag, "/count"},     int'(outstanding),   m_cnt);
    check({tag, "/overflow"},  int'(overflow_err),  int'(m_ov));
    check({tag, "/underflow"}, int'(underflow_err), int'(m_un));
    check({tag, "/timeout"},   int'(timeout_err),   int'(m_to));
  endtask

  task automatic model_reset();
    m_cnt = 0; m_phase = P_IDLE; m_age = 0;
    m_ov = 0; m_un = 0; m_to = 0;
  endtask

  // One clock of the specification's rules, using the inputs that were stable at the edge.
  task automatic model_step();
    bit inc, dec, ov_ev, un_ev, to_ev;
    int nc, np;
    inc = obs_if.req_valid_obs && obs_if.req_ready_obs;
    dec = obs_if.rsp_valid_obs && obs_if.rsp_ready_obs && obs_if.rsp_last_obs;
    ov_ev = 0; un_ev = 0; to_ev = 0;
    nc = m_cnt;
    if (inc && !dec) begin
      if (m_cnt == int'(MAXO)) ov_ev = 1; else nc = m_cnt + 1;
    end else if (dec && !inc) begin
      if (m_cnt == 0) un_ev = 1; else nc = m_cnt - 1;
    end
    if ((m_phase == P_WAIT || m_phase == P_DRAIN) && m_age < int'(TMO)) begin
      m_age++;
      if (m_age == int'(TMO)) to_ev = 1;
    end
    np = m_phase;
    case (m_phase)
      P_IDLE:  if (quiesce_req) np = P_WAIT;
      P_WAIT:  if (!quiesce_req) np = P_IDLE; else if (!obs_if.req_valid_obs || inc) np = P_DRAIN;
      P_DRAIN: if (!quiesce_req) np = P_IDLE; else if (nc == 0) np = P_DONE;
      default: if (!quiesce_req) np = P_IDLE;
    endcase
    if (np == P_WAIT && m_phase != P_WAIT) m_age = 0;
    m_ov = ov_ev || (m_ov && !err_clear);
    m_un = un_ev || (m_un && !err_clear);
    m_to = to_ev || (m_to && !err_clear);
    m_cnt = nc;
    m_phase = np;
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    #1;
    model_step();
    check_all(tag);
  endtask

  task automatic drive(input logic q, input logic rv, input logic rr,
                       input logic sv, input logic sr, input logic sl, input logic clr);
    quiesce_req          = q;
    obs_if.req_valid_obs = rv;
    obs_if.req_ready_obs = rr;
    obs_if.rsp_valid_obs = sv;
    obs_if.rsp_ready_obs = sr;
    obs_if.rsp_last_obs  = sl;
    err_clear            = clr;
  endtask

  initial begin
    // Reset state
    rstnn = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    model_reset();
    #12;
    check_all("reset");
    @(posedge clk); #1;
    rstnn = 1'b1;

    // Idle channel: block after 2 edges, ack after 3
    drive(1, 0, 0, 0, 0, 0, 0);
    tick("t1_e0");
    check("t1_block_e0", int'(block), 0);
    tick("t1_e1");
    check("t1_block_e1", int'(block), 1);
    check("t1_ack_e1", int'(quiesce_ack), 0);
    tick("t1_e2");
    check("t1_ack_e2", int'(quiesce_ack), 1);
    check("t1_count", int'(outstanding), 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    tick("t1_release");
    check("t1_rel_block", int'(block), 0);
    check("t1_rel_ack", int'(quiesce_ack), 0);
    tick("t1_idle");

    // Three requests then drain with staggered last beats
    drive(0, 1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) tick("t2_req");
    drive(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      if (i == 4 || i == 8 || i == 14) drive(1, 0, 0, 1, 1, 1, 0);
      else                             drive(1, 0, 0, 1, 1, 0, 0);
      tick("t2_drain");
      if (i == 13) check("t2_ack_before_last", int'(quiesce_ack), 0);
    end
    check("t2_ack_after_last", int'(quiesce_ack), 1);
    check("t2_block", int'(block), 1);
    drive(0, 0, 0, 0, 0, 0, 1);
    tick("t2_release");
    drive(0, 0, 0, 0, 0, 0, 0);
    tick("t2_idle");

    // Valid held without ready: stay unblocked until the handshake completes
    drive(1, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) tick("t3_pend");
    check("t3_block_pend", int'(block), 0);
    drive(1, 1, 1, 0, 0, 0, 0);
    tick("t3_hs");
    check("t3_block_after_hs", int'(block), 1);
    drive(1, 0, 0, 1, 1, 1, 0);
    tick("t3_rsp");
    check("t3_ack_same_cycle_rsp", int'(quiesce_ack), 1);
    drive(0, 0, 0, 0, 0, 0, 0);
    tick("t3_release");

    // Abort during drain with two outstanding
    drive(0, 1, 1, 0, 0, 0, 0);
    tick("t4_req"); tick("t4_req");
    drive(1, 0, 0, 0, 0, 0, 0);
    tick("t4_pend"); tick("t4_drain");
    check("t4_block_drain", int'(block), 1);
    drive(0, 0, 0, 0, 0, 0, 0);
    tick("t4_abort");
    check("t4_block_abort", int'(block), 0);
    check("t4_ack_abort", int'(quiesce_ack), 0);
    check("t4_count_abort", int'(outstanding), 2);
    drive(0, 0, 0, 1, 1, 1, 0);
    tick("t4_rsp"); tick("t4_rsp");

    // Overflow at the saturation limit, then clear
    drive(0, 1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) tick("t5_req");
    check("t5_count_sat", int'(outstanding), int'(MAXO));
    check("t5_overflow", int'(overflow_err), 1);
    drive(0, 0, 0, 0, 0, 0, 1);
    tick("t5_clear");
    check("t5_overflow_cleared", int'(overflow_err), 0);
    drive(0, 0, 0, 1, 1, 1, 0);
    for (int i = 0; i < 4; i++) tick("t5_rsp");

    // Unanswered request: watchdog fires eight cycles after PEND entry
    drive(0, 1, 1, 0, 0, 0, 1);
    tick("t6_req");
    drive(1, 0, 0, 0, 0, 0, 0);
    tick("t6_pend_entry");
    for (int i = 0; i < 7; i++) tick("t6_wait");
    check("t6_timeout_early", int'(timeout_err), 0);
    tick("t6_wait8");
    check("t6_timeout", int'(timeout_err), 1);
    check("t6_block", int'(block), 1);
    check("t6_ack", int'(quiesce_ack), 0);
    tick("t6_hold");

    // Asynchronous reset mid-drain
    @(negedge clk);
    rstnn = 1'b0;
    #1;
    model_reset();
    check("t7_block_async", int'(block), 0);
    check("t7_ack_async", int'(quiesce_ack), 0);
    check("t7_count_async", int'(outstanding), 0);
    check("t7_timeout_async", int'(timeout_err), 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    rstnn = 1'b1;
    tick("t7_after");

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      logic q;
      q = quiesce_req;
      if ($urandom_range(0, 15) == 0) q = ~q;
      drive(q, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 19) == 0));
      tick("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
